// File: rtl/mca_decimating_accumulator.sv
// mca_decimating_accumulator: decimating chunked adder of signed operands; in clk/reset/start/operands/sample_ready, out sample/sample_valid/busy/overrun
module mca_decimating_accumulator #(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int NUM_OPERANDS = 64,
  parameter int OPS_PER_CLK = 8,
  parameter int WIDTH_OUT = 32,
  parameter int SATURATE = 0,
  parameter int DOWNSAMPLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] operands [NUM_OPERANDS],
  input  logic sample_ready,
  output logic signed [WIDTH_OUT-1:0] sample,
  output logic sample_valid,
  output logic busy,
  output logic overrun
);
  localparam int C = (NUM_OPERANDS + OPS_PER_CLK - 1) / OPS_PER_CLK;
  localparam int WA = WIDTH_COEFFICIENT + $clog2(NUM_OPERANDS);
  localparam int CW = C > 1 ? $clog2(C) : 1;
  localparam int DW = DOWNSAMPLE > 1 ? $clog2(DOWNSAMPLE) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_n;
  logic signed [WIDTH_COEFFICIENT-1:0] pad [C][OPS_PER_CLK];
  logic signed [WIDTH_COEFFICIENT-1:0] ops_q [C][OPS_PER_CLK];
  logic signed [WA-1:0] acc, acc_sum, chunk_sum;
  logic signed [WIDTH_OUT-1:0] conv;
  logic [CW-1:0] chunk;
  logic [DW-1:0] dcnt;
  logic handshake, open, accept, compute, last;
  for (genvar c = 0; c < C; c++) begin : g_row
    for (genvar j = 0; j < OPS_PER_CLK; j++) begin : g_col
      if (c * OPS_PER_CLK + j < NUM_OPERANDS) begin : g_op
        assign pad[c][j] = operands[c * OPS_PER_CLK + j];
      end else begin : g_zero
        assign pad[c][j] = '0;
      end
    end
  end
  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < OPS_PER_CLK; i++) chunk_sum += WA'(ops_q[chunk][i]);
  end
  assign acc_sum = acc + chunk_sum;
  if (WIDTH_OUT >= WA) begin : g_ext
    assign conv = WIDTH_OUT'(acc_sum);
  end else if (SATURATE != 0) begin : g_sat
    logic [WA-WIDTH_OUT:0] top;
    assign top = acc_sum[WA-1:WIDTH_OUT-1];
    assign conv = (&top || ~|top) ? acc_sum[WIDTH_OUT-1:0] : {acc_sum[WA-1], {(WIDTH_OUT-1){~acc_sum[WA-1]}}};
  end else begin : g_wrap
    assign conv = acc_sum[WIDTH_OUT-1:0];
  end
  assign handshake = state == HOLD && sample_ready;
  assign open = state == IDLE || handshake;
  assign accept = start && open;
  assign compute = accept && dcnt == '0;
  assign last = state == ACCUM && chunk == CW'(C - 1);
  assign busy = state != IDLE;
  always_comb state_n = compute ? ACCUM : last ? HOLD : handshake ? IDLE : state;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (compute) ops_q <= pad;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      chunk <= '0;
      dcnt <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= start && !open;
      if (accept) dcnt <= dcnt == DW'(DOWNSAMPLE - 1) ? '0 : dcnt + 1'b1;
      if (compute) begin
        acc <= '0;
        chunk <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_sum;
        chunk <= chunk + 1'b1;
      end
      if (last) begin
        sample <= conv;
        sample_valid <= 1'b1;
      end else if (handshake) sample_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mca_decimating_accumulator.sv
// tb_mca_decimating_accumulator: scoreboard bench over saturating, wrapping and sign-extending instances
module tb_mca_decimating_accumulator;
  localparam int N = 10;
  localparam int C = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic sample_ready = 1'b0;
  logic signed [7:0] ops [N];
  logic signed [7:0] s0, s1;
  logic signed [15:0] smp [3];
  logic bsy [3], vld [3], ovr [3];
  int wo [3] = '{8, 8, 16};
  int sat [3] = '{1, 0, 0};
  int ds [3] = '{1, 2, 3};
  int last_acc [3], dc [3];
  bit hold [3], exp_busy [3], exp_valid [3], exp_over [3];
  int exp_q [3][$];
  int t = 0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign smp[0] = 16'(s0);
  assign smp[1] = 16'(s1);
  mca_decimating_accumulator #(.WIDTH_COEFFICIENT(8), .NUM_OPERANDS(N), .OPS_PER_CLK(4), .WIDTH_OUT(8), .SATURATE(1), .DOWNSAMPLE(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .operands(ops), .sample_ready(sample_ready),
    .sample(s0), .sample_valid(vld[0]), .busy(bsy[0]), .overrun(ovr[0]));
  mca_decimating_accumulator #(.WIDTH_COEFFICIENT(8), .NUM_OPERANDS(N), .OPS_PER_CLK(4), .WIDTH_OUT(8), .SATURATE(0), .DOWNSAMPLE(2)) u1 (
    .clk(clk), .reset(reset), .start(start), .operands(ops), .sample_ready(sample_ready),
    .sample(s1), .sample_valid(vld[1]), .busy(bsy[1]), .overrun(ovr[1]));
  mca_decimating_accumulator #(.WIDTH_COEFFICIENT(8), .NUM_OPERANDS(N), .OPS_PER_CLK(4), .WIDTH_OUT(16), .SATURATE(0), .DOWNSAMPLE(3)) u2 (
    .clk(clk), .reset(reset), .start(start), .operands(ops), .sample_ready(sample_ready),
    .sample(smp[2]), .sample_valid(vld[2]), .busy(bsy[2]), .overrun(ovr[2]));
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0d: got %0d required %0d", name, t, act, req);
    end
  endtask
  function automatic int conv(input int s, input int k);
    int hi, m;
    if (wo[k] >= 12) return s;
    hi = (1 << (wo[k] - 1)) - 1;
    if (sat[k] != 0) return s > hi ? hi : s < -hi - 1 ? -hi - 1 : s;
    m = s & ((1 << wo[k]) - 1);
    return m > hi ? m - (1 << wo[k]) : m;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      last_acc[k] = -100;
      dc[k] = 0;
      hold[k] = 0;
      exp_busy[k] = 0;
      exp_valid[k] = 0;
      exp_over[k] = 0;
      exp_q[k].delete();
    end
  endtask
  task automatic step(input bit st, input bit rdy);
    int sum;
    bit in_acc, ok;
    start = st;
    sample_ready = rdy;
    @(posedge clk);
    sum = 0;
    for (int i = 0; i < N; i++) sum += int'(ops[i]);
    for (int k = 0; k < 3; k++) begin
      in_acc = (t - last_acc[k]) inside {[1:C]};
      ok = !in_acc && (!hold[k] || rdy);
      if (hold[k] && rdy) hold[k] = 0;
      exp_over[k] = st && !ok;
      if (st && ok) begin
        if (dc[k] == 0) begin
          exp_q[k].push_back(conv(sum, k));
          last_acc[k] = t;
        end
        dc[k] = (dc[k] + 1) % ds[k];
      end
      if (t + 1 == last_acc[k] + C + 1) hold[k] = 1;
      exp_valid[k] = hold[k];
      exp_busy[k] = ((t + 1 - last_acc[k]) inside {[1:C]}) || hold[k];
    end
    t++;
    #1;
    start = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy%0d", k), int'(bsy[k]), 0);
      check($sformatf("rst_valid%0d", k), int'(vld[k]), 0);
      check($sformatf("rst_overrun%0d", k), int'(ovr[k]), 0);
      check($sformatf("rst_sample%0d", k), int'(smp[k]), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask
  task automatic run_set();
    step(1, 1);
    repeat (5) step(0, 1);
  endtask
  always @(negedge clk)
    if (!reset)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("busy%0d", k), int'(bsy[k]), int'(exp_busy[k]));
        check($sformatf("overrun%0d", k), int'(ovr[k]), int'(exp_over[k]));
        check($sformatf("valid%0d", k), int'(vld[k]), int'(exp_valid[k]));
        if (vld[k]) begin
          if (exp_q[k].size() == 0) check($sformatf("unexpected_sample%0d", k), exp_q[k].size(), 1);
          else begin
            check($sformatf("sample%0d", k), int'(smp[k]), exp_q[k][0]);
            if (sample_ready) void'(exp_q[k].pop_front());
          end
        end
      end
  initial begin
    for (int i = 0; i < N; i++) ops[i] = '0;
    model_reset();
    #1;
    do_reset();
    for (int i = 0; i < N; i++) ops[i] = 8'(i + 1);
    step(1, 0);
    for (int i = 0; i < N; i++) ops[i] = 8'($urandom);
    repeat (8) step(0, 0);
    step(0, 1);
    step(0, 0);
    for (int p = 0; p < 3; p++)
      repeat (6) begin
        for (int i = 0; i < N; i++) ops[i] = p == 0 ? (i % 2 != 0 ? 8'sd3 : -8'sd7) : p == 1 ? 8'sd127 : -8'sd128;
        run_set();
      end
    do_reset();
    for (int v = 1; v <= 6; v++) begin
      for (int i = 0; i < N; i++) ops[i] = 8'(v);
      run_set();
    end
    for (int i = 0; i < N; i++) ops[i] = 8'($urandom);
    step(1, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    step(0, 1);
    step(0, 1);
    repeat (4) run_set();
    repeat (6) begin
      for (int i = 0; i < N; i++) ops[i] = 8'($urandom);
      step(1, 1);
      repeat (3) step(0, 1);
    end
    repeat (4) step(0, 1);
    step(1, 1);
    step(0, 1);
    do_reset();
    for (int i = 0; i < N; i++) ops[i] = 8'(i + 1);
    run_set();
    repeat (400) begin
      for (int i = 0; i < N; i++) ops[i] = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 0 ? 8'sd127 : -8'sd128) : 8'($urandom);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (10) step(0, 1);
    for (int k = 0; k < 3; k++) check($sformatf("drain%0d", k), exp_q[k].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
